// File: rtl/overdrive_multimode_if.sv
// Sample stream bundle for the overdrive stage: valid-qualified input
// sample/mode/gain in, processed sample and the current slewed gain out.
interface overdrive_multimode_if #(
    parameter int FXP_SIZE  = 16,
    parameter int GAIN_SIZE = 16,
    parameter int OUT_SIZE  = 2*FXP_SIZE
);
    logic                        i_valid;
    logic signed [FXP_SIZE-1:0]  i_sample;
    logic        [GAIN_SIZE-1:0] i_gain;
    logic        [1:0]           i_mode;
    logic                        o_valid;
    logic signed [OUT_SIZE-1:0]  o_sample;
    logic        [GAIN_SIZE-1:0] o_gain;

    modport master (
        output i_valid, i_sample, i_gain, i_mode,
        input  o_valid, o_sample, o_gain
    );

    modport slave (
        input  i_valid, i_sample, i_gain, i_mode,
        output o_valid, o_sample, o_gain
    );
endinterface

// File: rtl/overdrive_multimode.sv
// Overdrive stage: sample x slew-limited gain, then one of four clippers
// (bypass / hard / cubic soft / asymmetric), saturated to the output width.
// Three register stages, valid-only stream, no backpressure.
module overdrive_multimode #(
    parameter int FXP_SIZE       = 16,
    parameter int BITS_PER_LEVEL = 12,
    parameter int GAIN_SIZE      = 16,
    parameter int GAIN_FRAC      = 4,
    parameter int RAMP_STEP      = 1,
    parameter int OUT_SIZE       = 2*FXP_SIZE
) (
    input  logic                   clk,
    input  logic                   rst,
    overdrive_multimode_if.slave   bus
);
    // Product width, cube width, working width for clip math, saturation width.
    localparam int W  = FXP_SIZE + GAIN_SIZE + 1;
    localparam int CW = 3*(BITS_PER_LEVEL + 2);
    localparam int EW = (W > CW) ? W : CW;
    localparam int SW = (EW > OUT_SIZE) ? EW : OUT_SIZE;

    localparam logic signed [EW-1:0] LV  = EW'(1 << BITS_PER_LEVEL);
    localparam logic signed [EW-1:0] LN  = -LV;
    localparam logic signed [EW-1:0] LHN = -(LV >>> 1);
    localparam logic signed [SW-1:0] OMAX = {{(SW-OUT_SIZE+1){1'b0}}, {(OUT_SIZE-1){1'b1}}};
    localparam logic signed [SW-1:0] OMIN = {{(SW-OUT_SIZE+1){1'b1}}, {(OUT_SIZE-1){1'b0}}};
    localparam logic [GAIN_SIZE-1:0] UNITY = GAIN_SIZE'(1 << GAIN_FRAC);
    localparam logic [GAIN_SIZE:0]   STEPW = (GAIN_SIZE+1)'(RAMP_STEP);
    localparam logic [GAIN_SIZE-1:0] STEP  = GAIN_SIZE'(RAMP_STEP);

    logic        [GAIN_SIZE-1:0] r_g;
    logic        [2:0]           r_vld_pipe;
    logic signed [W-1:0]         r_p;
    logic        [1:0]           r_mode;
    logic signed [EW-1:0]        r_y;
    logic signed [OUT_SIZE-1:0]  r_out;

    logic        [GAIN_SIZE-1:0] w_g_next;
    logic        [GAIN_SIZE:0]   w_tgt, w_cur;
    logic signed [W-1:0]         w_sx, w_gx, w_prod;
    logic signed [EW-1:0]        w_pe, w_c, w_ca, w_cube, w_soft, w_y;
    logic signed [SW-1:0]        w_ys;
    logic signed [OUT_SIZE-1:0]  w_sat;

    // Next slewed gain: step toward target, snap when within one step.
    always_comb begin
        w_tgt    = {1'b0, bus.i_gain};
        w_cur    = {1'b0, r_g};
        w_g_next = r_g;
        if (w_tgt > w_cur)
            w_g_next = ((w_tgt - w_cur) <= STEPW) ? bus.i_gain : r_g + STEP;
        else if (w_tgt < w_cur)
            w_g_next = ((w_cur - w_tgt) <= STEPW) ? bus.i_gain : r_g - STEP;
    end

    // Gain multiply; operands widened so the product cannot wrap.
    always_comb begin
        w_sx   = $signed({{(W-FXP_SIZE){bus.i_sample[FXP_SIZE-1]}}, bus.i_sample});
        w_gx   = $signed({{(W-GAIN_SIZE){1'b0}}, r_g});
        w_prod = w_sx * w_gx;
    end

    // Clipper selected by the mode that travelled with this sample.
    always_comb begin
        w_pe   = EW'(r_p);
        w_c    = (w_pe > LV) ? LV : ((w_pe < LN) ? LN : w_pe);
        w_ca   = (w_pe > LV) ? LV : ((w_pe < LHN) ? LHN : w_pe);
        w_cube = w_c * w_c * w_c;
        w_soft = w_c + (w_c >>> 1) - (w_cube >>> (2*BITS_PER_LEVEL + 1));
        w_y    = w_pe;
        case (r_mode)
            2'd1:    w_y = w_c;
            2'd2:    w_y = w_soft;
            2'd3:    w_y = w_ca;
            default: w_y = w_pe;
        endcase
    end

    // Saturate the clipped value into the output range.
    always_comb begin
        w_ys  = SW'(r_y);
        w_sat = OUT_SIZE'(w_ys);
        if (w_ys > OMAX)      w_sat = OUT_SIZE'(OMAX);
        else if (w_ys < OMIN) w_sat = OUT_SIZE'(OMIN);
    end

    // Gain register and the three pipeline stages; output holds during bubbles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_g        <= UNITY;
            r_vld_pipe <= '0;
            r_p        <= '0;
            r_mode     <= '0;
            r_y        <= '0;
            r_out      <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[1:0], bus.i_valid};
            if (bus.i_valid) begin
                r_g    <= w_g_next;
                r_p    <= w_prod >>> GAIN_FRAC;
                r_mode <= bus.i_mode;
            end
            if (r_vld_pipe[0]) r_y   <= w_y;
            if (r_vld_pipe[1]) r_out <= w_sat;
        end
    end

    assign bus.o_valid  = r_vld_pipe[2];
    assign bus.o_sample = r_out;
    assign bus.o_gain   = r_g;
endmodule

// File: tb/tb_overdrive_multimode.sv
// Directed bench: a 32-bit-output and a 16-bit-output instance fed the same
// stream; outputs sampled on the falling edge, inputs changed there too.
module tb_overdrive_multimode;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    overdrive_multimode_if #(.FXP_SIZE(16), .GAIN_SIZE(16), .OUT_SIZE(32)) bw ();
    overdrive_multimode_if #(.FXP_SIZE(16), .GAIN_SIZE(16), .OUT_SIZE(16)) bn ();

    assign bn.i_valid  = bw.i_valid;
    assign bn.i_sample = bw.i_sample;
    assign bn.i_gain   = bw.i_gain;
    assign bn.i_mode   = bw.i_mode;

    overdrive_multimode #(.OUT_SIZE(32)) dut_w (.clk(clk), .rst(rst), .bus(bw));
    overdrive_multimode #(.OUT_SIZE(16)) dut_n (.clk(clk), .rst(rst), .bus(bn));

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs, then advance to the next falling edge.
    task automatic push(input logic v, input int s, input int m, input int g);
        bw.i_valid  = v;
        bw.i_sample = 16'(s);
        bw.i_mode   = 2'(m);
        bw.i_gain   = 16'(g);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic outw(input string tag, input logic v, input longint s);
        chk({tag, "_valid"}, longint'(bw.o_valid), longint'(v));
        chk({tag, "_sample"}, longint'(bw.o_sample), s);
    endtask

    initial begin
        // Reset with random inputs applied.
        bw.i_valid = 1'b1; bw.i_sample = 16'($urandom); bw.i_mode = 2'($urandom);
        bw.i_gain  = 16'($urandom);
        repeat (3) @(negedge clk);
        outw("rst_hold", 1'b0, 0);
        chk("rst_gain", longint'(bw.o_gain), 16);
        push(1'b0, 0, 1, 16);
        rst = 1'b1;
        repeat (3) push(1'b0, 0, 1, 16);
        outw("rst_rel", 1'b0, 0);
        chk("rst_rel_gain", longint'(bw.o_gain), 16);

        // Hard clip, back-to-back.
        push(1'b1, 2000, 1, 16);
        push(1'b1, 5000, 1, 16);
        push(1'b1, -5000, 1, 16);
        outw("hard0", 1'b1, 2000);
        push(1'b0, 0, 1, 16);
        outw("hard1", 1'b1, 4096);
        push(1'b0, 0, 1, 16);
        outw("hard2", 1'b1, -4096);
        push(1'b0, 0, 1, 16);
        outw("hard_hold", 1'b0, -4096);

        // Cubic soft clip.
        push(1'b1, 2048, 2, 16);
        push(1'b1, 4096, 2, 16);
        push(1'b1, 8000, 2, 16);
        outw("soft0", 1'b1, 2816);
        push(1'b1, -2048, 2, 16);
        outw("soft1", 1'b1, 4096);
        push(1'b0, 0, 2, 16);
        outw("soft2", 1'b1, 4096);
        push(1'b0, 0, 2, 16);
        outw("soft3", 1'b1, -2816);

        // Asymmetric clip; mode switches per sample.
        push(1'b1, -3000, 3, 16);
        push(1'b1, 3000, 3, 16);
        push(1'b1, 5000, 3, 16);
        outw("asym0", 1'b1, -2048);
        push(1'b1, 3000, 0, 16);
        outw("asym1", 1'b1, 3000);
        push(1'b0, 0, 0, 16);
        outw("asym2", 1'b1, 4096);
        push(1'b0, 0, 0, 16);
        outw("byp_after_asym", 1'b1, 3000);
        chk("gain_unity", longint'(bw.o_gain), 16);

        // Gain ramp 16 -> 20 with gaps between valid samples.
        push(1'b1, 1000, 0, 20);
        chk("ramp_g0", longint'(bw.o_gain), 17);
        push(1'b0, 0, 0, 20);
        chk("ramp_gap", longint'(bw.o_gain), 17);
        push(1'b1, 1000, 0, 20);
        outw("ramp0", 1'b1, 1000);
        chk("ramp_g1", longint'(bw.o_gain), 18);
        push(1'b0, 0, 0, 20);
        chk("ramp_bubble", longint'(bw.o_valid), 0);
        push(1'b1, 1000, 0, 20);
        outw("ramp1", 1'b1, 1062);
        push(1'b0, 0, 0, 20);
        push(1'b1, 1000, 0, 20);
        outw("ramp2", 1'b1, 1125);
        chk("ramp_g3", longint'(bw.o_gain), 20);
        push(1'b0, 0, 0, 20);
        push(1'b1, 1000, 0, 20);
        outw("ramp3", 1'b1, 1187);
        chk("ramp_g_final", longint'(bw.o_gain), 20);
        push(1'b0, 0, 0, 20);
        push(1'b0, 0, 0, 20);
        outw("ramp4", 1'b1, 1250);

        // Ramp to 32, then bypass doubling and 16-bit output saturation.
        for (int k = 0; k < 12; k++) push(1'b1, 0, 0, 32);
        chk("gain32", longint'(bw.o_gain), 32);
        push(1'b0, 0, 0, 32);
        push(1'b0, 0, 0, 32);
        push(1'b1, 1000, 0, 32);
        push(1'b1, 30000, 0, 32);
        push(1'b1, -30000, 0, 32);
        outw("byp32", 1'b1, 2000);
        chk("byp32_n", longint'(bn.o_sample), 2000);
        push(1'b0, 0, 0, 32);
        chk("sat_pos_w", longint'(bw.o_sample), 60000);
        chk("sat_pos_n", longint'(bn.o_sample), 32767);
        push(1'b0, 0, 0, 32);
        chk("sat_neg_w", longint'(bw.o_sample), -60000);
        chk("sat_neg_n", longint'(bn.o_sample), -32768);
        chk("sat_neg_nv", longint'(bn.o_valid), 1);

        // Reset with samples in flight.
        push(1'b1, 500, 0, 32);
        push(1'b1, 600, 0, 32);
        bw.i_valid = 1'b1; bw.i_sample = 16'(700);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_valid", longint'(bw.o_valid), 0);
        chk("midrst_gain", longint'(bw.o_gain), 16);
        bw.i_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            push(1'b0, 0, 0, 16);
            chk("midrst_quiet", longint'(bw.o_valid), 0);
        end
        chk("midrst_gain_after", longint'(bw.o_gain), 16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
